// File: rtl/haze_synthesis.sv
`default_nettype none
// ============================================================================
// Module   : haze_synthesis
// Brief    : Forward haze model I = A + (J - A)*t. Three-stage elastic pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module haze_synthesis #(
   parameter int PIXELS_PER_FRAME = 262144,
   parameter int CNT_W            = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  J_R,
   input  logic [7:0]  J_G,
   input  logic [7:0]  J_B,
   input  logic [7:0]  A_R,
   input  logic [7:0]  A_G,
   input  logic [7:0]  A_B,
   input  logic [15:0] transmission,
   input  logic        i_valid,
   output logic        i_ready,
   output logic [7:0]  I_R,
   output logic [7:0]  I_G,
   output logic [7:0]  I_B,
   output logic        o_valid,
   input  logic        o_ready,
   output logic        o_frame_done
);

   localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(PIXELS_PER_FRAME - 1);

   logic               r_v1, r_v2, r_v3;
   logic signed [8:0]  r_diff [3];
   logic [7:0]         r_a1   [3];
   logic [15:0]        r_t1;
   logic signed [25:0] r_prod [3];
   logic [7:0]         r_a2   [3];
   logic [7:0]         r_out  [3];
   logic [CNT_W-1:0]   r_cnt;

   logic [7:0] w_j [3];
   logic [7:0] w_a [3];
   logic       w_en1, w_en2, w_en3;

   assign w_j[0] = J_R;
   assign w_j[1] = J_G;
   assign w_j[2] = J_B;
   assign w_a[0] = A_R;
   assign w_a[1] = A_G;
   assign w_a[2] = A_B;

   // Each stage may load when empty or when its successor frees a slot this cycle.
   assign w_en3   = !r_v3 || o_ready;
   assign w_en2   = !r_v2 || w_en3;
   assign w_en1   = !r_v1 || w_en2;
   assign i_ready = !rst && w_en1;

   assign o_valid      = r_v3;
   assign I_R          = r_out[0];
   assign I_G          = r_out[1];
   assign I_B          = r_out[2];
   assign o_frame_done = r_v3 && (r_cnt == c_LAST_IDX);

   // Round half toward +inf, add back A, clamp to the 8-bit pixel range.
   function automatic logic [7:0] f_recombine(input logic [7:0] a, input logic signed [25:0] prod);
      logic signed [25:0] v_rnd;
      logic signed [9:0]  v_q;
      logic signed [10:0] v_sum;
      v_rnd = prod + 26'sd32768;
      v_q   = v_rnd[25:16];
      v_sum = $signed({3'b000, a}) + $signed({v_q[9], v_q});
      if (v_sum < 0)
         return 8'd0;
      else if (v_sum > 11'sd255)
         return 8'd255;
      else
         return v_sum[7:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_t1  <= '0;
         r_cnt <= '0;
         for (int c = 0; c < 3; c++) begin
            r_diff[c] <= '0;
            r_a1[c]   <= '0;
            r_prod[c] <= '0;
            r_a2[c]   <= '0;
            r_out[c]  <= '0;
         end
      end else begin
         if (w_en1) begin
            r_v1 <= i_valid;
            if (i_valid) begin
               r_t1 <= transmission;
               for (int c = 0; c < 3; c++) begin
                  r_diff[c] <= $signed({1'b0, w_j[c]}) - $signed({1'b0, w_a[c]});
                  r_a1[c]   <= w_a[c];
               end
            end
         end
         if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               for (int c = 0; c < 3; c++) begin
                  r_prod[c] <= r_diff[c] * $signed({1'b0, r_t1});
                  r_a2[c]   <= r_a1[c];
               end
            end
         end
         if (w_en3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
               for (int c = 0; c < 3; c++)
                  r_out[c] <= f_recombine(r_a2[c], r_prod[c]);
            end
         end
         if (r_v3 && o_ready) begin
            if (r_cnt == c_LAST_IDX)
               r_cnt <= '0;
            else
               r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_haze_synthesis.sv
`default_nettype none
// ============================================================================
// Module   : tb_haze_synthesis
// Brief    : Directed bench for haze_synthesis with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_haze_synthesis;

   localparam int PPF = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  J_R = '0, J_G = '0, J_B = '0;
   logic [7:0]  A_R = '0, A_G = '0, A_B = '0;
   logic [15:0] transmission = '0;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic [7:0]  I_R, I_G, I_B;
   logic        o_valid;
   logic        o_ready = 1'b1;
   logic        o_frame_done;

   int checks   = 0;
   int failures = 0;

   logic [23:0] exp_q[$];
   int          done_log[$];
   int          n_out = 0;
   logic        have_prev = 1'b0;
   logic [23:0] prev_data = '0;
   logic        saw_stall_in = 1'b0;

   haze_synthesis #(.PIXELS_PER_FRAME(PPF), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .J_R(J_R), .J_G(J_G), .J_B(J_B),
      .A_R(A_R), .A_G(A_G), .A_B(A_B),
      .transmission(transmission),
      .i_valid(i_valid), .i_ready(i_ready),
      .I_R(I_R), .I_G(I_G), .I_B(I_B),
      .o_valid(o_valid), .o_ready(o_ready),
      .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Haze model from first principles: A + round-half-up((J-A)*t/65536), clamped.
   function automatic int chan(input int j, input int a, input int t);
      real v;
      int  r;
      v = real'(a) + $floor((real'(j) - real'(a)) * real'(t) / 65536.0 + 0.5);
      r = int'(v);
      if (r < 0) r = 0;
      if (r > 255) r = 255;
      return r;
   endfunction

   function automatic logic [23:0] model(input int jr, jg, jb, ar, ag, ab, t);
      return {8'(chan(jr, ar, t)), 8'(chan(jg, ag, t)), 8'(chan(jb, ab, t))};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         done_log.delete();
         n_out     = 0;
         have_prev = 1'b0;
      end else begin
         if (have_prev) begin
            chk("stall_valid_hold", {31'd0, o_valid}, 32'd1);
            chk("stall_data_hold", {8'd0, I_R, I_G, I_B}, {8'd0, prev_data});
         end
         have_prev = o_valid && !o_ready;
         prev_data = {I_R, I_G, I_B};
         if (!o_valid)
            chk("frame_done_idle", {31'd0, o_frame_done}, 32'd0);
         if (o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               chk("out_beat", {7'd0, I_R, I_G, I_B, o_frame_done},
                   {7'd0, e, ((n_out % PPF) == PPF - 1)});
            end
            n_out++;
            if (o_frame_done) done_log.push_back(n_out);
         end
         if (i_valid && i_ready)
            exp_q.push_back(model(J_R, J_G, J_B, A_R, A_G, A_B, transmission));
         if (i_valid && !i_ready)
            saw_stall_in = 1'b1;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the beat transferred.
   task automatic send(input logic [7:0] jr, jg, jb, ar, ag, ab, input logic [15:0] t);
      int w;
      J_R = jr; J_G = jg; J_B = jb;
      A_R = ar; A_G = ag; A_B = ab;
      transmission = t;
      i_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!i_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!i_ready) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic send_lat(input string nm, input logic [7:0] jr, jg, jb, ar, ag, ab,
                           input logic [15:0] t, input logic [23:0] lit);
      send(jr, jg, jb, ar, ag, ab, t);
      @(negedge clk);
      chk({nm, "_lat1"}, {31'd0, o_valid}, 32'd0);
      @(negedge clk);
      chk({nm, "_lat2"}, {31'd0, o_valid}, 32'd0);
      @(negedge clk);
      chk({nm, "_lat3"}, {31'd0, o_valid}, 32'd1);
      chk({nm, "_value"}, {8'd0, I_R, I_G, I_B}, {8'd0, lit});
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] vals [6];
      time        t0;
      vals = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};

      #1;
      chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_data", {8'd0, I_R, I_G, I_B}, 32'd0);
      chk("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
      chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Half-way: 100+50, 255-127.5 rounds up to 128, equal channel stays 100.
      send_lat("basic", 8'd200, 8'd0, 8'd100, 8'd100, 8'd255, 8'd100, 16'h8000, {8'd150, 8'd128, 8'd100});
      send_lat("quarter", 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 16'h4000, {8'd191, 8'd191, 8'd191});
      send_lat("t_zero", 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 16'h0000, {8'd255, 8'd255, 8'd255});
      drain();

      t0 = $time;
      for (int j = 0; j < 6; j++)
         for (int a = 0; a < 6; a++)
            send(vals[j], vals[(j + 1) % 6], vals[(j + 2) % 6],
                 vals[a], vals[(a + 3) % 6], vals[(a + 5) % 6], 16'hFFFF);
      chk("identity_rate", 32'(($time - t0) / 10), 32'd36);
      drain();

      saw_stall_in = 1'b0;
      fork
         begin
            for (int k = 0; k < 20; k++)
               send(8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
         end
         begin
            for (int k = 0; k < 40; k++) begin
               o_ready = (k >= 4 && k < 9) ? 1'b0 : 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
            o_ready = 1'b1;
         end
      join
      drain();
      chk("bp_iready_fell", {31'd0, saw_stall_in}, 32'd1);

      for (int k = 0; k < 3; k++)
         send(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 16'h1234);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_o_valid", {31'd0, o_valid}, 32'd0);
      chk("arst_data", {8'd0, I_R, I_G, I_B}, 32'd0);
      chk("arst_frame_done", {31'd0, o_frame_done}, 32'd0);
      chk("arst_i_ready", {31'd0, i_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      send_lat("fresh", 8'd40, 8'd80, 8'd120, 8'd0, 8'd0, 8'd0, 16'h8000, {8'd20, 8'd40, 8'd60});
      for (int k = 0; k < 8; k++)
         send(8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
      drain();
      chk("frame_beats", n_out, 32'd9);
      chk("frame_done_count", done_log.size(), 32'd2);
      if (done_log.size() >= 2) begin
         chk("frame_done_first", done_log[0], 32'd4);
         chk("frame_done_second", done_log[1], 32'd8);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
